// File: rtl/alu_pkg.sv
// Shared types and defaults for the sliced ALU core: opcode and FSM state
// encodings plus the default slice geometry.
package alu_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_ALU = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_MUL = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/alu_core_if.sv
// Operand/result bus of the ALU core. Both sides use valid/ready: a transfer
// happens on a rising edge where valid and ready are both high (and enable is high).
interface alu_core_if #(
    parameter int DW = 16
);
    import alu_pkg::*;

    logic          enable;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    select;
    logic          out_valid;
    logic          out_ready;
    logic [2*DW-1:0] out;
    logic          carry_out;
    logic          sign_bit;
    logic          a_greater;
    logic          a_equal;
    logic          a_less;
    state_e        dbg_state;

    modport master (
        output enable, in_valid, a, b, select, out_ready,
        input  in_ready, out_valid, out, carry_out, sign_bit,
        input  a_greater, a_equal, a_less, dbg_state
    );

    modport slave (
        input  enable, in_valid, a, b, select, out_ready,
        output in_ready, out_valid, out, carry_out, sign_bit,
        output a_greater, a_equal, a_less, dbg_state
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per enabled cycle,
// DW steps after start, then done stays high until the next start.
module alu_mul_iter #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en_i,
    input  logic          start_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [2*DW-1:0] prod_o
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] LAST = CW'(DW - 1);

    logic [2*DW-1:0] mcand_q;
    logic [2*DW-1:0] acc_q, acc_d;
    logic [DW-1:0]   mplier_q;
    logic [CW-1:0]   count_q;
    logic            busy_q;
    logic            done_q;

    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (en_i) begin
            if (start_i) begin
                mcand_q  <= {{DW{1'b0}}, a_i};
                mplier_q <= b_i;
                acc_q    <= '0;
                count_q  <= '0;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end else if (busy_q) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + 1'b1;
                if (count_q == LAST) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/alu_core.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative multiply, results
// registered and held in HOLD until the consumer takes them.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_ALU = DEF_N_ALU
) (
    input logic       clk,
    input logic       arst,
    alu_core_if.slave bus
);
    localparam int DW = WIDTH * N_ALU;

    state_e state_q, state_d;
    op_e    op_q, op_in;
    logic [DW-1:0] a_q, b_q;
    logic          rdy_en_q;

    logic [2*DW-1:0] out_q, out_d;
    logic carry_q, carry_d, sign_q, sign_d;
    logic gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
    logic [DW:0] sum;

    logic accept, load_res, mul_start;
    logic mul_busy, mul_done;
    logic [2*DW-1:0] mul_prod;

    assign op_in = op_e'(bus.select);

    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign bus.in_ready = bus.enable && rdy_en_q &&
                          ((state_q == ST_IDLE) || (state_q == ST_HOLD && bus.out_ready));
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_res  = 1'b0;
        mul_start = 1'b0;
        if (bus.enable) begin
            case (state_q)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        state_d   = (op_in == OP_MUL) ? ST_MUL : ST_EXEC;
                        mul_start = (op_in == OP_MUL);
                    end else if (state_q == ST_HOLD && bus.out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    state_d  = ST_HOLD;
                    load_res = 1'b1;
                end
                ST_MUL: begin
                    if (mul_done && !mul_busy) begin
                        state_d  = ST_HOLD;
                        load_res = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        out_d   = '0;
        carry_d = 1'b0;
        sign_d  = 1'b0;
        gt_d    = (a_q > b_q);
        eq_d    = (a_q == b_q);
        lt_d    = (a_q < b_q);
        case (op_q)
            OP_ADD: begin
                out_d   = {{DW{1'b0}}, sum[DW-1:0]};
                carry_d = sum[DW];
            end
            OP_SUB: begin
                if (lt_d) begin
                    out_d   = {{DW{1'b0}}, b_q - a_q};
                    sign_d  = 1'b1;
                    carry_d = 1'b1;
                end else begin
                    out_d = {{DW{1'b0}}, a_q - b_q};
                end
            end
            OP_AND:  out_d = {{DW{1'b0}}, a_q & b_q};
            OP_OR:   out_d = {{DW{1'b0}}, a_q | b_q};
            OP_XOR:  out_d = {{DW{1'b0}}, a_q ^ b_q};
            OP_SHL:  out_d = {{DW{1'b0}}, a_q} << b_q[3:0];
            OP_MUL:  out_d = mul_prod;
            default: out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rdy_en_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            out_q    <= '0;
            carry_q  <= 1'b0;
            sign_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (accept) begin
                a_q  <= bus.a;
                b_q  <= bus.b;
                op_q <= op_in;
            end
            if (load_res) begin
                out_q   <= out_d;
                carry_q <= carry_d;
                sign_q  <= sign_d;
                gt_q    <= gt_d;
                eq_q    <= eq_d;
                lt_q    <= lt_d;
            end
        end
    end

    alu_mul_iter #(.DW(DW)) u_mul (
        .clk     (clk),
        .arst    (arst),
        .en_i    (bus.enable),
        .start_i (mul_start),
        .a_i     (bus.a),
        .b_i     (bus.b),
        .busy_o  (mul_busy),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.sign_bit  = sign_q;
    assign bus.a_greater = gt_q;
    assign bus.a_equal   = eq_q;
    assign bus.a_less    = lt_q;
    assign bus.dbg_state = state_q;

endmodule
